serial2mii: RTL and testbench

- Reverse path of the MII-to-UART bridge: accepts bytes from a UART receiver, buffers them, and emits complete Ethernet-style frames on an MII transmit interface generated from the system clock.
- Each frame is preamble + SFD followed by buffered payload.
- Sits in the emulator top between uart_rx (byte strobe) and the MII pins driven toward the device under test.

---
 rtl/serial2mii_if.sv | 20 ++
 rtl/serial2mii.sv | 185 ++++++++++++++++++
 tb/tb_serial2mii.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial2mii_if.sv
// Byte-strobe input side and MII transmit side of the serial-to-MII bridge.
interface serial2mii_if;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       mii_clk;
  logic       mii_en;
  logic [3:0] mii_d;
  logic       busy;
  logic       overflow;

  modport master (
    output rx_dv, rx_byte,
    input  mii_clk, mii_en, mii_d, busy, overflow
  );

  modport slave (
    input  rx_dv, rx_byte,
    output mii_clk, mii_en, mii_d, busy, overflow
  );
endinterface

// File: rtl/serial2mii.sv
// Buffers UART bytes in a FIFO and sends them as preamble+SFD framed payload on MII TX.
//   state    | meaning
//   IDLE     | waiting for a full frame's worth of bytes or an idle timeout
//   PREAMBLE | 15 nibbles of 0x5 then the 0xD SFD nibble
//   DATA     | payload, low nibble first, one FIFO pop per byte
//   IPG      | mii_en low for IPG_NIBBLES ticks
module serial2mii #(
  parameter int CLK_DIV     = 4,
  parameter int FIFO_DEPTH  = 128,
  parameter int FRAME_MAX   = 128,
  parameter int IDLE_CLKS   = 17360,
  parameter int IPG_NIBBLES = 24
) (
  input logic        clk,
  input logic        reset_n,
  serial2mii_if.slave bus
);

  localparam int DW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int OW  = PW + 1;
  localparam int TW  = $clog2(IDLE_CLKS + 1);
  localparam int LW  = $clog2(FRAME_MAX + 1);
  localparam int ICW = $clog2(IPG_NIBBLES + 1);
  localparam int CW  = (ICW > 5) ? ICW : 5;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, IPG} state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic            mii_clk_q;
  logic            mii_en_q;
  logic [3:0]      mii_d_q;
  logic            busy_q;
  logic            overflow_q;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;
  logic [7:0]      head;
  logic            wr_ok;
  logic            pop;

  logic [TW-1:0]   idle_tmr;
  logic            expired;
  logic            start;

  logic [LW-1:0]   frame_len;
  logic [LW-1:0]   byte_cnt;
  logic            half;
  logic [3:0]      hi_nib;
  logic [CW-1:0]   nib_cnt;

  assign tick    = (div_cnt == DW'(CLK_DIV - 1));
  assign expired = (idle_tmr == TW'(IDLE_CLKS));
  assign wr_ok   = bus.rx_dv && (occ != OW'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];
  assign pop     = tick && (state == DATA) && !half && (byte_cnt != frame_len);
  assign start   = (occ >= OW'(FRAME_MAX)) || (expired && (occ != '0));

  assign bus.mii_clk  = mii_clk_q;
  assign bus.mii_en   = mii_en_q;
  assign bus.mii_d    = mii_d_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

  // mii_clk is low for the first half of the divider period, so a tick is its falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      mii_clk_q <= 1'b0;
    end else if (tick) begin
      div_cnt   <= '0;
      mii_clk_q <= 1'b0;
    end else begin
      div_cnt   <= div_cnt + DW'(1);
      mii_clk_q <= (div_cnt >= DW'(CLK_DIV / 2 - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_tmr <= '0;
    end else if (bus.rx_dv) begin
      idle_tmr <= '0;
    end else if (!expired) begin
      idle_tmr <= idle_tmr + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.rx_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (bus.rx_dv && !wr_ok) overflow_q <= 1'b1;
    end
  end

  // The SFD nibble is driven on the tick that enters DATA; the tick after the last
  // high nibble drops mii_en and enters IPG.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mii_en_q  <= 1'b0;
      mii_d_q   <= 4'h0;
      busy_q    <= 1'b0;
      frame_len <= '0;
      byte_cnt  <= '0;
      half      <= 1'b0;
      hi_nib    <= 4'h0;
      nib_cnt   <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PREAMBLE;
            busy_q    <= 1'b1;
            mii_en_q  <= 1'b1;
            mii_d_q   <= 4'h5;
            nib_cnt   <= CW'(1);
            frame_len <= (occ >= OW'(FRAME_MAX)) ? LW'(FRAME_MAX) : LW'(occ);
          end
        end
        PREAMBLE: begin
          if (nib_cnt == CW'(15)) begin
            state    <= DATA;
            mii_d_q  <= 4'hD;
            byte_cnt <= '0;
            half     <= 1'b0;
          end else begin
            mii_d_q  <= 4'h5;
            nib_cnt  <= nib_cnt + CW'(1);
          end
        end
        DATA: begin
          if (half) begin
            mii_d_q  <= hi_nib;
            half     <= 1'b0;
            byte_cnt <= byte_cnt + LW'(1);
          end else if (byte_cnt == frame_len) begin
            state    <= IPG;
            mii_en_q <= 1'b0;
            mii_d_q  <= 4'h0;
            nib_cnt  <= '0;
          end else begin
            mii_d_q  <= head[3:0];
            hi_nib   <= head[7:4];
            half     <= 1'b1;
          end
        end
        IPG: begin
          if (nib_cnt == CW'(IPG_NIBBLES - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            nib_cnt <= nib_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          mii_en_q <= 1'b0;
          mii_d_q  <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial2mii.sv
// Directed bench for serial2mii: byte scoreboard, MII frame capture and edge-timing monitor.
module tb_serial2mii;

  localparam int CLK_DIV     = 4;
  localparam int FIFO_DEPTH  = 128;
  localparam int FRAME_MAX   = 128;
  localparam int IDLE_CLKS   = 17360;
  localparam int IPG_NIBBLES = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  serial2mii_if bus();

  serial2mii #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_MAX(FRAME_MAX),
    .IDLE_CLKS(IDLE_CLKS), .IPG_NIBBLES(IPG_NIBBLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb_q[$];
  logic [3:0] obs_q[$];
  int flen_q[$];
  int gap_q[$];
  int ipg_q[$];

  bit in_frame = 0;
  bit have_prev = 0;
  bit ipg_on = 0;
  int cur_len = 0;
  int low_cnt = 0;
  int ipg_cnt = 0;
  int rises = 0;

  int edge_viol = 0;
  int clk_viol = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MII capture at the mii_clk rising edge
  initial begin
    forever begin
      @(posedge bus.mii_clk);
      #1;
      if (reset_n) begin
        if (bus.mii_en) begin
          if (!in_frame) begin
            in_frame = 1;
            rises++;
            if (have_prev) gap_q.push_back(low_cnt);
            cur_len = 0;
          end
          obs_q.push_back(bus.mii_d);
          cur_len++;
          ipg_on = 0;
        end else begin
          if (in_frame) begin
            in_frame = 0;
            flen_q.push_back(cur_len);
            have_prev = 1;
            low_cnt = 0;
            ipg_on = 1;
            ipg_cnt = 0;
          end
          low_cnt++;
          if (ipg_on) begin
            if (bus.busy) ipg_cnt++;
            else begin
              ipg_q.push_back(ipg_cnt);
              ipg_on = 0;
            end
          end
        end
      end
    end
  end

  // mii_en/mii_d may only move on a mii_clk falling edge; mii_clk halves are CLK_DIV/2 long
  initial begin
    logic pe, pc;
    logic [3:0] pd;
    bit pr;
    int run;
    bit run_ok;
    pe = 0; pc = 0; pd = 0; pr = 0; run = 0; run_ok = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && pr) begin
        if ((bus.mii_en !== pe || bus.mii_d !== pd) && !(pc === 1'b1 && bus.mii_clk === 1'b0))
          edge_viol++;
        if (bus.mii_clk !== pc) begin
          if (run_ok && run != CLK_DIV / 2) clk_viol++;
          run = 1;
          run_ok = 1;
        end else begin
          run++;
        end
      end else begin
        run = 0;
        run_ok = 0;
      end
      pe = bus.mii_en; pd = bus.mii_d; pc = bus.mii_clk; pr = reset_n;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit keep);
    @(negedge clk);
    bus.rx_dv = 1'b1;
    bus.rx_byte = b;
    if (keep) sb_q.push_back(b);
    @(negedge clk);
    bus.rx_dv = 1'b0;
  endtask

  task automatic wait_rise(input int max_clks, output bit ok);
    ok = 0;
    for (int i = 0; i < max_clks; i++) begin
      @(posedge clk);
      #1;
      if (bus.mii_en) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int nbytes, input int max_clks);
    bit ok;
    int len;
    logic [3:0] exp_n[$];
    logic [3:0] n;
    logic [7:0] b;
    ok = 0;
    for (int i = 0; i < max_clks; i++) begin
      if (flen_q.size() > 0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
    end
    check({tag, " frame_seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    len = flen_q.pop_front();
    for (int i = 0; i < 15; i++) exp_n.push_back(4'h5);
    exp_n.push_back(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
      exp_n.push_back(b[3:0]);
      exp_n.push_back(b[7:4]);
    end
    check({tag, " nibble_count"}, 32'(len), 32'(exp_n.size()));
    for (int i = 0; i < len; i++) begin
      n = obs_q.pop_front();
      if (i < exp_n.size()) check($sformatf("%s nib%0d", tag, i), 32'(n), 32'(exp_n[i]));
    end
  endtask

  initial begin
    bit ok;
    int rises_before;
    bus.rx_dv = 1'b0;
    bus.rx_byte = 8'h00;
    reset_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset mii_clk", 32'(bus.mii_clk), 32'd0);
    check("reset mii_en", 32'(bus.mii_en), 32'd0);
    check("reset mii_d", 32'(bus.mii_d), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single byte flushed by the idle timeout
    send_byte(8'hA5, 1);
    repeat (100) @(posedge clk);
    #1;
    check("single no_early_start", 32'(bus.mii_en), 32'd0);
    check_frame("single", 1, IDLE_CLKS + 400);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (ipg_q.size() > 0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
    end
    check("single ipg_seen", 32'(ok), 32'd1);
    if (ok) check("single ipg_busy_nibbles", 32'(ipg_q.pop_front()), 32'(IPG_NIBBLES));
    #1;
    check("single busy_after_ipg", 32'(bus.busy), 32'd0);

    // FRAME_MAX bytes start a frame without waiting for the timeout
    for (int i = 0; i < FRAME_MAX - 1; i++) begin
      send_byte(8'(i), 1);
      repeat (8) @(negedge clk);
    end
    #1;
    check("maxlen no_early_start", 32'(bus.mii_en), 32'd0);
    send_byte(8'(FRAME_MAX - 1), 1);
    ok = 0;
    for (int i = 0; i < CLK_DIV; i++) begin
      @(posedge clk);
      #1;
      if (bus.mii_en) begin
        ok = 1;
        break;
      end
    end
    check("maxlen start_latency", 32'(ok), 32'd1);
    check_frame("maxlen", FRAME_MAX, 3000);
    check("maxlen overflow", 32'(bus.overflow), 32'd0);
    repeat (150) @(posedge clk);

    // overflow: 130 back-to-back bytes, the last two are dropped
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      bus.rx_dv = 1'b1;
      bus.rx_byte = 8'(i);
      if (i < FIFO_DEPTH) sb_q.push_back(8'(i));
    end
    @(negedge clk);
    bus.rx_dv = 1'b0;
    @(negedge clk);
    check("ovf overflow_set", 32'(bus.overflow), 32'd1);
    check_frame("ovf", FRAME_MAX, 3000);
    check("ovf overflow_sticky", 32'(bus.overflow), 32'd1);
    repeat (150) @(posedge clk);

    // writes during transmission go to the next frame
    send_byte(8'h11, 1);
    repeat (8) @(negedge clk);
    send_byte(8'h22, 1);
    repeat (8) @(negedge clk);
    send_byte(8'h3C, 1);
    wait_rise(IDLE_CLKS + 400, ok);
    check("wdt first_rise", 32'(ok), 32'd1);
    check("wdt busy", 32'(bus.busy), 32'd1);
    send_byte(8'h4B, 1);
    send_byte(8'hE7, 1);
    check_frame("wdt first", 3, 600);
    gap_q.delete();
    check_frame("wdt second", 2, IDLE_CLKS + 800);
    check("wdt gap_count", 32'(gap_q.size()), 32'd1);
    if (gap_q.size() > 0) check("wdt gap_ge_ipg", 32'(gap_q.pop_front() >= IPG_NIBBLES), 32'd1);
    check("wdt overflow_sticky", 32'(bus.overflow), 32'd1);
    repeat (150) @(posedge clk);

    // asynchronous reset in the middle of DATA
    send_byte(8'h96, 1);
    send_byte(8'h69, 1);
    send_byte(8'hC3, 1);
    send_byte(8'h3C, 1);
    wait_rise(IDLE_CLKS + 400, ok);
    check("rst frame_started", 32'(ok), 32'd1);
    repeat (20 * CLK_DIV) @(posedge clk);
    #1;
    check("rst in_data en", 32'(bus.mii_en), 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst async mii_en", 32'(bus.mii_en), 32'd0);
    check("rst async mii_d", 32'(bus.mii_d), 32'd0);
    check("rst async mii_clk", 32'(bus.mii_clk), 32'd0);
    check("rst async busy", 32'(bus.busy), 32'd0);
    check("rst async overflow", 32'(bus.overflow), 32'd0);
    in_frame = 0;
    have_prev = 0;
    ipg_on = 0;
    obs_q.delete();
    sb_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rises_before = rises;
    repeat (IDLE_CLKS + 400) @(posedge clk);
    #1;
    check("rst no_frame rises", 32'(rises), 32'(rises_before));
    check("rst no_frame flen", 32'(flen_q.size()), 32'd0);
    check("rst idle mii_en", 32'(bus.mii_en), 32'd0);
    check("rst idle busy", 32'(bus.busy), 32'd0);

    check("edge timing violations", 32'(edge_viol), 32'd0);
    check("mii_clk half-period violations", 32'(clk_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
